fsgnj_arbiter: RTL
==================

// Module: fsgnj_arbiter
// PURPOSE
//  Shares one sign-injection datapath (FSGNJ/FSGNJN/FSGNJX) between two requesters.
//  Port 0 is the FP issue stage, port 1 is the FMV/misc path; both use valid/ready.
//  Round-robin arbitration selects one request per cycle and computes the result.
//  The result and its tag enter a 2-entry output FIFO with its own valid/ready handshake.
// PARAMETERS
//  BUS_WIDTH  64  operand width; 64 = binary64 (exp 11, mant 52), 32 = binary32 (exp 8, mant 23)
//  TAG_W      5   destination-register tag width carried with each request
// PORTS
//  clk          in   1          clock; all state updates on the rising edge
//  rst          in   1          synchronous reset, active high
//  r0_valid     in   1          requester 0 holds a valid request
//  r0_ready     out  1          requester 0 request accepted this cycle (when r0_valid=1)
//  r0_op        in   2          requester 0 op: 00 J, 01 JN, 10 JX, 11 MV
//  r0_in1       in   BUS_WIDTH  requester 0 magnitude source operand
//  r0_in2       in   BUS_WIDTH  requester 0 sign source operand
//  r0_tag       in   TAG_W      requester 0 destination tag
//  r1_*         same as r0_*, for requester 1
//  out_valid    out  1          output FIFO head is valid
//  out_ready    in   1          consumer takes the FIFO head this cycle
//  out_data     out  BUS_WIDTH  result at the FIFO head
//  out_tag      out  TAG_W      tag at the FIFO head
//  out_src      out  1          requester index (0/1) for the FIFO head
// BEHAVIOUR
//  - Reset: FIFO count=0, rd/wr ptr=0, out_valid=0, out_data/out_tag/out_src=0.
//    last_grant=1, so requester 0 wins the first conflict.
//  - full = (count==2). Arbitration is combinational:
//    only one valid -> that requester gets the grant;
//    both valid -> the requester != last_grant gets the grant.
//  - rN_ready = grant_N & ~full. At most one ready is high per cycle.
//    Ready never depends on out_ready (no combinational path from out_ready).
//  - Accept = rN_valid & rN_ready. On accept:
//    the result is written at wr_ptr; wr_ptr toggles; last_grant <= N.
//    With no accept, last_grant holds.
//  - Result is computed in the accept cycle (S1=in1 sign, S2=in2 sign):
//    nan2 = (in2 exp field all ones) & (in2 mantissa != 0); qNaN and sNaN both count.
//    nan2=1 -> result = in1 unchanged, for every op.
//    else J: {S2, in1[W-2:0]}; JN: {~S2, in1[W-2:0]};
//         JX: {S1^S2, in1[W-2:0]}; MV: in1.
//    Infinities and zeros are not NaN; the sign rule applies to them.
//  - Dequeue = out_valid & out_ready; rd_ptr toggles.
//    out_* show the entry at rd_ptr. out_valid = (count!=0).
//  - count next: +1 on accept only; -1 on dequeue only;
//    unchanged on both or neither. count never exceeds 2 or goes below 0.
//  - When full, no accept occurs, even if out_ready=1 in the same cycle.
//    Sustained throughput is 1/cycle while count <= 1.
//  - Latency: accept in cycle t -> out_valid with that result in cycle t+1, if the FIFO was empty.
//  - Ordering: results leave in acceptance order, across both requesters.
//  - Requesters must hold op/in1/in2/tag stable while valid & ~ready.
//    The block does not check this.
//  - Reset mid-operation: all FIFO contents are discarded and last_grant=1.
//    out_valid=0 in the cycle after rst; no partial or stale result is ever presented.
// TESTING (BUS_WIDTH=64)
//  - r0 J, in1=3FF0000000000000, in2=C000000000000000, tag=3, out_ready=1
//    -> next cycle out_data=BFF0000000000000, out_tag=3, out_src=0.
//  - Same operands with JN -> 3FF0000000000000; with JX -> BFF0000000000000.
//    MV -> 3FF0000000000000.
//  - r1 J, in2=7FF8000000000001 (NaN), in1=3FF0000000000000 -> 3FF0000000000000.
//    in2=FFF0000000000000 (-inf) -> BFF0000000000000.
//  - r0 and r1 valid every cycle from reset, out_ready=1
//    -> accept order r0,r1,r0,r1; out_src alternates 0,1,0,1; one accept per cycle.
//  - out_ready=0, r0 issues tags 1,2,3 -> tags 1,2 accepted, count=2, r0_ready=0 for tag 3.
//    out_ready=1 -> tags emerge 1,2,3 in order.
//  - count=2 with a pending request, rst=1 for one cycle -> out_valid=0, count=0.
//    The next conflict is granted to r0.

Source files
------------

// File: rtl/fsgnj_arbiter.sv
// Two-requester round-robin front end for a shared FSGNJ/FSGNJN/FSGNJX datapath.
// Results are queued in a 2-entry FIFO in acceptance order.
module fsgnj_arbiter #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_W     = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_valid,
  output logic                 r0_ready,
  input  logic [1:0]           r0_op,
  input  logic [BUS_WIDTH-1:0] r0_in1,
  input  logic [BUS_WIDTH-1:0] r0_in2,
  input  logic [TAG_W-1:0]     r0_tag,
  input  logic                 r1_valid,
  output logic                 r1_ready,
  input  logic [1:0]           r1_op,
  input  logic [BUS_WIDTH-1:0] r1_in1,
  input  logic [BUS_WIDTH-1:0] r1_in2,
  input  logic [TAG_W-1:0]     r1_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_src
);

  localparam int EXP_W  = (BUS_WIDTH == 64) ? 11 : 8;
  localparam int MANT_W = BUS_WIDTH - 1 - EXP_W;

  localparam logic [1:0] OP_J  = 2'b00;
  localparam logic [1:0] OP_JN = 2'b01;
  localparam logic [1:0] OP_JX = 2'b10;

  logic [1:0]           count;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic                 last_grant;
  logic [BUS_WIDTH-1:0] data_q [2];
  logic [TAG_W-1:0]     tag_q  [2];
  logic                 src_q  [2];

  logic                 full;
  logic                 grant0;
  logic                 grant1;
  logic                 acc0;
  logic                 acc1;
  logic                 acc;
  logic                 deq;
  logic [1:0]           sel_op;
  logic [BUS_WIDTH-1:0] sel_in1;
  logic [BUS_WIDTH-1:0] sel_in2;
  logic [TAG_W-1:0]     sel_tag;
  logic [BUS_WIDTH-1:0] result;

  function automatic logic [BUS_WIDTH-1:0] sgnj(
    input logic [1:0]           op,
    input logic [BUS_WIDTH-1:0] a,
    input logic [BUS_WIDTH-1:0] b
  );
    logic nan2;
    logic s1;
    logic s2;
    nan2 = (&b[BUS_WIDTH-2 -: EXP_W]) & (|b[MANT_W-1:0]);
    s1   = a[BUS_WIDTH-1];
    s2   = b[BUS_WIDTH-1];
    sgnj = a;
    // A NaN sign source leaves the magnitude operand untouched
    if (!nan2) begin
      case (op)
        OP_J:    sgnj = {s2, a[BUS_WIDTH-2:0]};
        OP_JN:   sgnj = {~s2, a[BUS_WIDTH-2:0]};
        OP_JX:   sgnj = {s1 ^ s2, a[BUS_WIDTH-2:0]};
        default: sgnj = a;
      endcase
    end
  endfunction

  assign full     = (count == 2'd2);
  assign grant0   = r0_valid & (~r1_valid | last_grant);
  assign grant1   = r1_valid & (~r0_valid | ~last_grant);
  assign r0_ready = grant0 & ~full;
  assign r1_ready = grant1 & ~full;
  assign acc0     = r0_valid & r0_ready;
  assign acc1     = r1_valid & r1_ready;
  assign acc      = acc0 | acc1;
  assign deq      = out_valid & out_ready;

  assign sel_op  = acc1 ? r1_op  : r0_op;
  assign sel_in1 = acc1 ? r1_in1 : r0_in1;
  assign sel_in2 = acc1 ? r1_in2 : r0_in2;
  assign sel_tag = acc1 ? r1_tag : r0_tag;
  assign result  = sgnj(sel_op, sel_in1, sel_in2);

  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      last_grant <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
        src_q[i]  <= 1'b0;
      end
    end else begin
      if (acc) begin
        data_q[wr_ptr] <= result;
        tag_q[wr_ptr]  <= sel_tag;
        src_q[wr_ptr]  <= acc1;
        wr_ptr         <= ~wr_ptr;
        last_grant     <= acc1;
      end
      if (deq) rd_ptr <= ~rd_ptr;
      case ({acc, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are forced to zero while empty so stale entries never show
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? data_q[rd_ptr] : '0;
  assign out_tag   = out_valid ? tag_q[rd_ptr]  : '0;
  assign out_src   = out_valid ? src_q[rd_ptr]  : 1'b0;

endmodule
